// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg : state encodings and default width for the serial adder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_adder_ctrl_pkg

`default_nettype wire

// File: rtl/full_gate.sv
// ---------------------------------------------------------------------------
// full_gate : 1-bit full adder from two half adders and an OR of their carries
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_gate (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    logic w_ab_sum;
    logic w_ab_carry;
    logic w_abc_carry;

    half_gate u_ha_ab (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (w_ab_sum),
        .carry_o (w_ab_carry)
    );

    half_gate u_ha_abc (
        .a_i     (w_ab_sum),
        .b_i     (c_i),
        .sum_o   (sum_o),
        .carry_o (w_abc_carry)
    );

    assign carry_o = w_ab_carry | w_abc_carry;

endmodule : full_gate

`default_nettype wire

// File: rtl/half_gate.sv
// ---------------------------------------------------------------------------
// half_gate : 1-bit half adder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module half_gate (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule : half_gate

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl : bit-serial LSB-first adder with IDLE/RUN/DONE control
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outS,
    output logic             outC
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   outs_q, outs_d;
    logic               outc_q, outc_d;

    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_next;

    full_gate u_full_gate (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .c_i     (carry_q),
        .sum_o   (w_sum),
        .carry_o (w_carry)
    );

    // Sum bits enter at the MSB so the LSB-first stream ends up in place.
    assign w_res_next = {w_sum, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        outs_d  = outs_q;
        outc_d  = outc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = inA;
                    b_d     = inB;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d   = w_res_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    outs_d  = w_res_next;
                    outc_d  = w_carry;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            outs_q  <= '0;
            outc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
            outc_q  <= outc_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign outS = outs_q;
    assign outC = outc_q;

endmodule : serial_adder_ctrl

`default_nettype wire
